// File: rtl/c64_bus_glue.sv
// c64_bus_glue: phi2 divider, CPU/DMA address mux, PLA bank decode and CPU read-data mux
module c64_bus_glue #(
    parameter int          DIV      = 8,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        dot_clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rw,
    input  logic [15:0] Ai,
    input  logic        RW,
    input  logic        DMA,
    input  logic [2:0]  port_bits,
    input  logic        GAME_n,
    input  logic        EXTROM_n,
    input  logic [7:0]  Di,
    input  logic [7:0]  ram_q,
    input  logic [7:0]  basic_q,
    input  logic [7:0]  kernal_q,
    input  logic [7:0]  char_q,
    input  logic [7:0]  io_q,
    output logic        phi2,
    output logic [15:0] Ao,
    output logic        bus_rw,
    output logic        ram_cs,
    output logic        basic_cs,
    output logic        kernal_cs,
    output logic        char_cs,
    output logic        io_cs,
    output logic        ROML,
    output logic        ROMH,
    output logic [7:0]  cpu_di,
    output logic [7:0]  d_latched
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phi2_q, phi2_d;
    logic [7:0]    d_latched_q, d_latched_d;
    logic          ultimax, cart8, cart16, loram, hiram, charen, en;
    logic [3:0]    pg;
    logic          dec_ram, dec_basic, dec_kernal, dec_char, dec_io, dec_roml, dec_romh;

    always_comb begin
        Ao      = DMA ? Ai : cpu_a;
        bus_rw  = DMA ? RW : cpu_rw;
        pg      = Ao[15:12];
        ultimax = !GAME_n && EXTROM_n;
        cart8   = GAME_n && !EXTROM_n;
        cart16  = !GAME_n && !EXTROM_n;
        loram   = port_bits[0];
        hiram   = port_bits[1];
        charen  = port_bits[2];
    end

    always_comb begin
        dec_ram    = 1'b0;
        dec_basic  = 1'b0;
        dec_kernal = 1'b0;
        dec_char   = 1'b0;
        dec_io     = 1'b0;
        dec_roml   = 1'b0;
        dec_romh   = 1'b0;
        if (ultimax) begin
            dec_ram  = pg == 4'h0;
            dec_roml = pg == 4'h8 || pg == 4'h9;
            dec_io   = pg == 4'hD;
            dec_romh = pg >= 4'hE;
        end else if (pg == 4'h8 || pg == 4'h9) begin
            dec_roml = (cart8 || cart16) && loram && hiram;
            dec_ram  = !dec_roml;
        end else if (pg == 4'hA || pg == 4'hB) begin
            dec_romh  = cart16 && hiram;
            dec_basic = !dec_romh && loram && hiram;
            dec_ram   = !dec_romh && !dec_basic;
        end else if (pg == 4'hD) begin
            dec_io   = (loram || hiram) && charen;
            dec_char = (loram || hiram) && !charen;
            dec_ram  = !(loram || hiram);
        end else if (pg >= 4'hE) begin
            dec_kernal = hiram;
            dec_ram    = !hiram;
        end else begin
            dec_ram = 1'b1;
        end
        // writes never reach ROMs: they land in RAM underneath, except in ultimax where ROM/open areas take nothing
        if (!bus_rw) begin
            dec_ram    = ultimax ? pg == 4'h0 : !dec_io;
            dec_basic  = 1'b0;
            dec_kernal = 1'b0;
            dec_char   = 1'b0;
            dec_roml   = 1'b0;
            dec_romh   = 1'b0;
        end
    end

    always_comb begin
        en        = phi2_q && reset;
        ram_cs    = en && dec_ram;
        basic_cs  = en && dec_basic;
        kernal_cs = en && dec_kernal;
        char_cs   = en && dec_char;
        io_cs     = en && dec_io;
        ROML      = en && dec_roml;
        ROMH      = en && dec_romh;
        cpu_di    = !bus_rw     ? OPEN_BUS :
                    ram_cs      ? ram_q    :
                    basic_cs    ? basic_q  :
                    kernal_cs   ? kernal_q :
                    char_cs     ? char_q   :
                    io_cs       ? io_q     :
                    ROML || ROMH ? Di      : OPEN_BUS;
        cnt_d       = cnt_q == CW'(DIV - 1) ? '0 : cnt_q + CW'(1);
        phi2_d      = cnt_d >= CW'(DIV / 2);
        d_latched_d = (phi2_q && !phi2_d && bus_rw) ? cpu_di : d_latched_q;
        phi2        = phi2_q;
        d_latched   = d_latched_q;
    end

    always_ff @(posedge dot_clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            phi2_q      <= 1'b0;
            d_latched_q <= 8'h00;
        end else begin
            cnt_q       <= cnt_d;
            phi2_q      <= phi2_d;
            d_latched_q <= d_latched_d;
        end
    end
endmodule

// File: tb/tb_c64_bus_glue.sv
// tb_c64_bus_glue: randomized check of c64_bus_glue against a range-based bank model
module tb_c64_bus_glue;
    logic        dot_clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_a = 16'h0000, Ai = 16'h0000;
    logic        cpu_rw = 1'b1, RW = 1'b1, DMA = 1'b0;
    logic [2:0]  port_bits = 3'b111;
    logic        GAME_n = 1'b1, EXTROM_n = 1'b1;
    logic [7:0]  Di = 8'h00, ram_q = 8'h00, basic_q = 8'h00, kernal_q = 8'h00, char_q = 8'h00, io_q = 8'h00;
    logic        phi2, bus_rw, ram_cs, basic_cs, kernal_cs, char_cs, io_cs, ROML, ROMH;
    logic [15:0] Ao;
    logic [7:0]  cpu_di, d_latched;

    c64_bus_glue dut (
        .dot_clk(dot_clk), .reset(reset), .cpu_a(cpu_a), .cpu_rw(cpu_rw), .Ai(Ai), .RW(RW),
        .DMA(DMA), .port_bits(port_bits), .GAME_n(GAME_n), .EXTROM_n(EXTROM_n), .Di(Di),
        .ram_q(ram_q), .basic_q(basic_q), .kernal_q(kernal_q), .char_q(char_q), .io_q(io_q),
        .phi2(phi2), .Ao(Ao), .bus_rw(bus_rw), .ram_cs(ram_cs), .basic_cs(basic_cs),
        .kernal_cs(kernal_cs), .char_cs(char_cs), .io_cs(io_cs), .ROML(ROML), .ROMH(ROMH),
        .cpu_di(cpu_di), .d_latched(d_latched)
    );

    always #5 dot_clk = ~dot_clk;

    int         n_chk = 0, n_fail = 0;
    int         k = 0;
    logic       exp_phi2 = 1'b0;
    logic [7:0] exp_dl = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 none, 1 ram, 2 basic, 3 kernal, 4 char, 5 io, 6 roml, 7 romh
    function automatic int target();
        int a, t;
        bit ult, lo, hi, ch, cart;
        a    = DMA ? int'(Ai) : int'(cpu_a);
        ult  = GAME_n == 1'b0 && EXTROM_n == 1'b1;
        cart = EXTROM_n == 1'b0;
        lo   = port_bits[0];
        hi   = port_bits[1];
        ch   = port_bits[2];
        if (ult) begin
            if (a < 'h1000) t = 1;
            else if (a >= 'h8000 && a < 'hA000) t = 6;
            else if (a >= 'hD000 && a < 'hE000) t = 5;
            else if (a >= 'hE000) t = 7;
            else t = 0;
        end else if (a >= 'h8000 && a < 'hA000) t = (cart && lo && hi) ? 6 : 1;
        else if (a >= 'hA000 && a < 'hC000) t = (!GAME_n && !EXTROM_n && hi) ? 7 : (lo && hi) ? 2 : 1;
        else if (a >= 'hD000 && a < 'hE000) t = (lo || hi) ? (ch ? 5 : 4) : 1;
        else if (a >= 'hE000) t = hi ? 3 : 1;
        else t = 1;
        if (!(DMA ? RW : cpu_rw)) t = (t == 5) ? 5 : (ult ? (t == 1 ? 1 : 0) : 1);
        return t;
    endfunction

    function automatic logic [6:0] exp_sel();
        int t;
        t = target();
        if (!reset || !exp_phi2 || t == 0) return 7'b0;
        return 7'(7'b1000000 >> (t - 1));
    endfunction

    function automatic logic [7:0] exp_di();
        int t;
        t = target();
        if (!reset || !exp_phi2 || !(DMA ? RW : cpu_rw)) return 8'hFF;
        case (t)
            1: return ram_q;
            2: return basic_q;
            3: return kernal_q;
            4: return char_q;
            5: return io_q;
            6, 7: return Di;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [6:0] sels();
        return {ram_cs, basic_cs, kernal_cs, char_cs, io_cs, ROML, ROMH};
    endfunction

    task automatic check_all();
        chk("phi2", phi2, exp_phi2);
        chk("Ao", Ao, DMA ? Ai : cpu_a);
        chk("bus_rw", bus_rw, DMA ? RW : cpu_rw);
        chk("selects", sels(), exp_sel());
        chk("cpu_di", cpu_di, exp_di());
        chk("d_latched", d_latched, exp_dl);
    endtask

    task automatic step();
        logic       pre_phi, pre_rw;
        logic [7:0] pre_di;
        pre_phi = exp_phi2;
        pre_di  = exp_di();
        pre_rw  = DMA ? RW : cpu_rw;
        @(posedge dot_clk);
        if (!reset) begin
            k = 0;
            exp_phi2 = 1'b0;
            exp_dl = 8'h00;
        end else begin
            k++;
            exp_phi2 = (k % 8) >= 4;
            if (pre_phi && !exp_phi2 && pre_rw) exp_dl = pre_di;
        end
        #3 check_all();
    endtask

    task automatic go_high();
        for (int i = 0; i < 16 && !exp_phi2; i++) step();
    endtask

    task automatic go_low();
        for (int i = 0; i < 16 && exp_phi2; i++) step();
    endtask

    initial begin
        repeat (5) step();
        chk("rst_phi2", phi2, 0);
        chk("rst_sel", sels(), 0);
        chk("rst_dl", d_latched, 8'h00);
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("phi2_seq", phi2, (i % 8) >= 4);
        end

        GAME_n = 1'b1; EXTROM_n = 1'b0; port_bits = 3'b111; cpu_a = 16'h8123; cpu_rw = 1'b1; Di = 8'hA5;
        go_low(); go_high();
        chk("roml_8k", ROML, 1);
        chk("roml_di", cpu_di, 8'hA5);
        go_low();
        chk("roml_latch", d_latched, 8'hA5);

        EXTROM_n = 1'b1; cpu_a = 16'hA000;
        go_high();
        chk("basic", basic_cs, 1);
        cpu_a = 16'hD020; #1 chk("io", io_cs, 1);
        port_bits = 3'b011; #1 chk("char", char_cs, 1);
        port_bits = 3'b000; cpu_a = 16'hE000; #1 chk("ram_e000", ram_cs, 1);
        port_bits = 3'b111; cpu_rw = 1'b0; #1 chk("wr_ram", ram_cs, 1);
        chk("wr_kernal", kernal_cs, 0);
        cpu_a = 16'hD400; #1 chk("wr_io", io_cs, 1);
        chk("wr_di", cpu_di, 8'hFF);
        cpu_rw = 1'b1; GAME_n = 1'b0; cpu_a = 16'hF000; #1 chk("ult_romh", ROMH, 1);
        cpu_a = 16'h4000; #1 chk("ult_open", sels(), 0);
        chk("ult_open_di", cpu_di, 8'hFF);
        cpu_a = 16'h0800; #1 chk("ult_ram", ram_cs, 1);
        GAME_n = 1'b1; EXTROM_n = 1'b0; DMA = 1'b1; Ai = 16'h9000; RW = 1'b1; cpu_a = 16'h0000;
        #1 chk("dma_ao", Ao, 16'h9000);
        chk("dma_roml", ROML, 1);
        DMA = 1'b0; #1 chk("nodma_ao", Ao, 16'h0000);
        chk("nodma_ram", ram_cs, 1);

        reset = 1'b0; #1 chk("rst_mid_sel", sels(), 0);
        step();
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("rst_mid_phi2", phi2, i >= 4);
        end

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) cpu_a = 16'($urandom);
            if ($urandom_range(0, 2) == 0) Ai = 16'($urandom);
            if ($urandom_range(0, 3) == 0) cpu_rw = 1'($urandom);
            if ($urandom_range(0, 3) == 0) RW = 1'($urandom);
            if ($urandom_range(0, 7) == 0) DMA = 1'($urandom);
            if ($urandom_range(0, 5) == 0) port_bits = 3'($urandom);
            if ($urandom_range(0, 7) == 0) {GAME_n, EXTROM_n} = 2'($urandom);
            reset = $urandom_range(0, 63) != 0;
            Di = 8'($urandom); ram_q = 8'($urandom); basic_q = 8'($urandom);
            kernal_q = 8'($urandom); char_q = 8'($urandom); io_q = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
